// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: idle-mode opcodes,
// burst controller states and burst direction values.
package shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: captures a clamped shift count and direction on start,
// then issues one shift-enable per cycle until the count is exhausted.
module shift_burst_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [LW-1:0] len,
  output logic          idle,
  output logic          shift_en,
  output logic          shift_dir,
  output logic          busy,
  output logic          done
);

  localparam logic [LW-1:0] MAX_LEN = LW'(WIDTH);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  state_t        state_reg, state_next;
  logic [LW-1:0] cnt_reg, cnt_next;
  logic          dir_reg, dir_next;
  logic [LW-1:0] len_clamped;

  // Requests longer than the register collapse to one full-width pass.
  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dir_reg   <= DIR_LEFT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    shift_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          dir_next   = dir;
          cnt_next   = len_clamped;
          state_next = (len_clamped == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        shift_en = 1'b1;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign idle      = (state_reg == IDLE);
  assign busy      = (state_reg == BURST);
  assign done      = (state_reg == DONE);
  assign shift_dir = dir_reg;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: per-cycle mode operations while idle, plus
// counted shift bursts sequenced by shift_burst_ctrl.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             si_r,
  input  logic             si_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  input  logic [LW-1:0]    len,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v;
  logic             idle;
  logic             shift_en;
  logic             shift_dir;
  logic             mode_en;

  shift_burst_ctrl #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .len       (len),
    .idle      (idle),
    .shift_en  (shift_en),
    .shift_dir (shift_dir),
    .busy      (busy),
    .done      (done)
  );

  // A start request owns the idle cycle, so mode is only honoured without it.
  assign mode_en = idle & ~start;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_nbr
      if (gi == 0) begin : g_lsb
        assign shl_v[gi] = si_r;
        assign rol_v[gi] = q_reg[WIDTH-1];
      end else begin : g_lo
        assign shl_v[gi] = q_reg[gi-1];
        assign rol_v[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_v[gi] = si_l;
        assign ror_v[gi] = q_reg[0];
      end else begin : g_hi
        assign shr_v[gi] = q_reg[gi+1];
        assign ror_v[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    q_next = q_reg;
    if (shift_en) begin
      q_next = (shift_dir == DIR_RIGHT) ? shr_v : shl_v;
    end else if (mode_en) begin
      case (mode)
        MODE_HOLD: q_next = q_reg;
        MODE_SHL:  q_next = shl_v;
        MODE_SHR:  q_next = shr_v;
        MODE_ROL:  q_next = rol_v;
        MODE_ROR:  q_next = ror_v;
        MODE_LOAD: q_next = pin;
        MODE_CLR:  q_next = '0;
        default:   q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q      = q_reg;
  assign so_msb = q_reg[WIDTH-1];
  assign so_lsb = q_reg[0];

endmodule
